// File: rtl/audio_capture_writer.sv
// audio_capture_writer: pops ADC FIFO samples and writes their top SAMPLE_W bits into a RAM window.
// Tracks the peak magnitude and flags illegal windows.
module audio_capture_writer #(
  parameter int ADDR_W   = 18,
  parameter int SAMPLE_W = 6,
  parameter int DECIM    = 1
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   rec_start,
  input  logic [ADDR_W-1:0]   rec_end,
  input  logic                audio_in_available,
  input  logic [31:0]         left_channel_audio_in,
  output logic                read_audio_in,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [SAMPLE_W-1:0] ram_data,
  output logic                ram_wren,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SAMPLE_W-1:0] peak
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
  logic [SAMPLE_W-1:0] data_q, data_d, peak_q, peak_d, s, mag;
  logic [7:0] decim_q, decim_d;
  logic err_q, err_d;
  logic unused_bits;
  assign unused_bits = ^left_channel_audio_in[31-SAMPLE_W:0];
  assign s   = left_channel_audio_in[31 -: SAMPLE_W];
  // Negating the most-negative code yields the same bit pattern, which read unsigned is 2^(SAMPLE_W-1).
  assign mag = s[SAMPLE_W-1] ? -s : s;
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      data_q  <= '0;
      peak_q  <= '0;
      decim_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      data_q  <= data_d;
      peak_q  <= peak_d;
      decim_q <= decim_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    data_d  = data_q;
    peak_d  = peak_q;
    decim_d = decim_q;
    err_d   = err_q;
    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        addr_d  = rec_start;
        end_d   = rec_end;
        peak_d  = '0;
        decim_d = '0;
        err_d   = rec_end < rec_start;
        state_d = (rec_end < rec_start) ? S_DONE : S_WAIT;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_WAIT:  state_d = audio_in_available ? S_READ : S_WAIT;
        S_READ: begin
          data_d  = s;
          peak_d  = (mag > peak_q) ? mag : peak_q;
          decim_d = (decim_q == 8'(DECIM - 1)) ? 8'd0 : decim_q + 8'd1;
          state_d = (decim_q == 8'd0) ? S_WRITE : S_WAIT;
        end
        S_WRITE: begin
          addr_d  = (addr_q == end_q) ? addr_q : addr_q + 1'b1;
          state_d = (addr_q == end_q) ? S_DONE : S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  assign read_audio_in = (state_q == S_READ) && !abort;
  assign ram_wren      = (state_q == S_WRITE) && !abort;
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_DONE;
  assign ram_addr      = addr_q;
  assign ram_data      = data_q;
  assign err           = err_q;
  assign peak          = peak_q;
endmodule
